// File: rtl/gif_sequencer.sv
// Frame-index sequencer for the sprite/ROM address path: runtime frame count and
// period, with loop, ping-pong and one-shot playback, pause/single-step and done.
module gif_sequencer #(
  parameter int MAX_FRAMES  = 16,
  parameter int FRAME_W     = $clog2(MAX_FRAMES),
  parameter int CNT_W       = 32,
  parameter int FRAME_SPEED = 12500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pause,
  input  logic               step,
  input  logic               restart,
  input  logic [1:0]         mode,
  input  logic [FRAME_W:0]   num_frames,
  input  logic [CNT_W-1:0]   speed,
  output logic [FRAME_W-1:0] frame_actual,
  output logic               frame_changed,
  output logic               dir,
  output logic               busy,
  output logic               done
);

  localparam int NW = FRAME_W + 1;
  localparam logic [NW-1:0]    MAX_N      = NW'(MAX_FRAMES);
  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(FRAME_SPEED);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [NW-1:0]    n_lat;
  logic [1:0]       mode_lat;

  logic [FRAME_W-1:0] adv_frame;
  logic               adv_dir;
  logic               adv_done;
  logic               adv_go;
  logic               boundary;
  logic               multi;
  logic               at_last;

  function automatic logic [NW-1:0] clamp_frames(input logic [NW-1:0] n);
    return (n > MAX_N) ? MAX_N : n;
  endfunction

  function automatic logic [CNT_W-1:0] period_sel(input logic [CNT_W-1:0] s);
    return (s == '0) ? DEF_PERIOD : s;
  endfunction

  // Next frame/direction from the latched count and mode; adv_done flags one-shot end.
  always_comb begin
    multi     = (n_lat > NW'(1));
    at_last   = ({1'b0, frame_actual} == n_lat - NW'(1));
    boundary  = (cnt == period - CNT_W'(1));
    adv_go    = ((state == RUN) && boundary) || ((state == PAUSE) && step);
    adv_frame = frame_actual;
    adv_dir   = dir;
    adv_done  = 1'b0;
    if (!multi) begin
      adv_done = (mode_lat == 2'b10);
    end else begin
      case (mode_lat)
        2'b01: begin
          if (!dir) begin
            if (at_last) begin
              adv_dir   = 1'b1;
              adv_frame = frame_actual - FRAME_W'(1);
            end else begin
              adv_frame = frame_actual + FRAME_W'(1);
            end
          end else begin
            if (frame_actual == '0) begin
              adv_dir   = 1'b0;
              adv_frame = frame_actual + FRAME_W'(1);
            end else begin
              adv_frame = frame_actual - FRAME_W'(1);
            end
          end
        end
        2'b10: begin
          if (at_last) adv_done  = 1'b1;
          else         adv_frame = frame_actual + FRAME_W'(1);
        end
        default: begin
          adv_frame = at_last ? '0 : frame_actual + FRAME_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      period        <= DEF_PERIOD;
      n_lat         <= '0;
      mode_lat      <= 2'b00;
      frame_actual  <= '0;
      frame_changed <= 1'b0;
      dir           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      frame_changed <= 1'b0;
      if (!enable) begin
        state        <= IDLE;
        cnt          <= '0;
        frame_actual <= '0;
        dir          <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
      end else if ((state == IDLE) || restart) begin
        // Fresh start: entry from IDLE or a restart from any active state.
        frame_changed <= (state != IDLE) && (frame_actual != '0);
        state         <= RUN;
        n_lat         <= clamp_frames(num_frames);
        mode_lat      <= mode;
        period        <= period_sel(speed);
        cnt           <= '0;
        frame_actual  <= '0;
        dir           <= 1'b0;
        busy          <= 1'b1;
        done          <= 1'b0;
      end else if (state != DONE) begin
        if ((state == RUN) && !boundary) cnt <= cnt + CNT_W'(1);
        if (adv_go) begin
          cnt <= '0;
          if (state == RUN) period <= period_sel(speed);
          if (adv_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            frame_actual  <= adv_frame;
            dir           <= adv_dir;
            frame_changed <= (adv_frame != frame_actual);
            state         <= pause ? PAUSE : RUN;
          end
        end else begin
          state <= pause ? PAUSE : RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_gif_sequencer.sv
// Randomized and directed bench for gif_sequencer against a position-based
// playback model (loop/ping-pong/one-shot expressed as a walk over positions).
module tb_gif_sequencer;

  localparam int MAXF = 16;
  localparam int FW   = 4;
  localparam int DEFP = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, pause = 1'b0, step = 1'b0, restart = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [FW:0]   num_frames = '0;
  logic [31:0]   speed = '0;
  logic [FW-1:0] frame_actual;
  logic          frame_changed, dir, busy, done;

  gif_sequencer #(.MAX_FRAMES(MAXF), .FRAME_W(FW), .CNT_W(32), .FRAME_SPEED(DEFP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pause(pause), .step(step),
    .restart(restart), .mode(mode), .num_frames(num_frames), .speed(speed),
    .frame_actual(frame_actual), .frame_changed(frame_changed), .dir(dir),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 run, 2 pause, 3 done; playback position m_pos and
  // cycles remaining until the next frame boundary m_rem.
  int m_state, m_pos, m_n, m_mode, m_per, m_rem;
  bit m_chg;

  function automatic int m_frame();
    if (m_mode == 1 && m_n >= 2 && m_pos >= m_n) return 2 * m_n - 2 - m_pos;
    return m_pos;
  endfunction

  function automatic int m_dir();
    return (m_mode == 1 && m_n >= 2 && m_pos >= m_n) ? 1 : 0;
  endfunction

  task automatic m_reset();
    m_state = 0; m_pos = 0; m_chg = 0; m_n = 0; m_mode = 0; m_per = DEFP; m_rem = DEFP;
  endtask

  task automatic m_latch();
    m_n    = (int'(num_frames) > MAXF) ? MAXF : int'(num_frames);
    m_mode = (mode == 2'b11) ? 0 : int'(mode);
    m_per  = (speed == 0) ? DEFP : int'(speed);
    m_rem  = m_per;
    m_pos  = 0;
    m_state = 1;
  endtask

  task automatic m_advance();
    int old_f;
    bit fin;
    old_f = m_frame();
    fin = 0;
    if (m_n < 2) fin = (m_mode == 2);
    else if (m_mode == 1) m_pos = (m_pos == 2 * m_n - 2) ? 1 : m_pos + 1;
    else if (m_mode == 2) begin
      if (m_pos == m_n - 1) fin = 1; else m_pos++;
    end else m_pos = (m_pos + 1) % m_n;
    if (fin) m_state = 3;
    else begin
      m_chg = (m_frame() != old_f);
      m_state = pause ? 2 : 1;
    end
  endtask

  task automatic m_step();
    int old_f;
    old_f = m_frame();
    m_chg = 0;
    if (!rst_n) m_reset();
    else if (!enable) begin m_state = 0; m_pos = 0; end
    else if (m_state == 0) m_latch();
    else if (restart) begin m_latch(); m_chg = (old_f != 0); end
    else if (m_state == 2 && step) begin m_rem = m_per; m_advance(); end
    else if (m_state == 1 && m_rem == 1) begin
      m_per = (speed == 0) ? DEFP : int'(speed);
      m_rem = m_per;
      m_advance();
    end else if (m_state == 1 || m_state == 2) begin
      if (m_state == 1) m_rem--;
      m_state = pause ? 2 : 1;
    end
  endtask

  task automatic check_all();
    chk("frame", 32'(frame_actual), 32'(m_frame()));
    chk("changed", 32'(frame_changed), 32'(m_chg));
    chk("dir", 32'(dir), 32'(m_dir()));
    chk("busy", 32'(busy), 32'((m_state == 1 || m_state == 2) ? 1 : 0));
    chk("done", 32'(done), 32'((m_state == 3) ? 1 : 0));
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask

  task automatic setup(input logic [1:0] md, input int nf, input int sp);
    enable = 1'b0; pause = 1'b0; step = 1'b0; restart = 1'b0;
    tick();
    mode = md; num_frames = (FW + 1)'(nf); speed = 32'(sp);
    enable = 1'b1;
    tick();
  endtask

  initial begin
    m_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Loop N=4, period 4: first change 4 cycles after entry
    setup(2'b00, 4, 4);
    repeat (3) tick();
    chk("t1_hold", 32'(frame_actual), 32'd0);
    tick();
    chk("t1_first", 32'(frame_actual), 32'd1);
    chk("t1_pulse", 32'(frame_changed), 32'd1);
    repeat (16) tick();

    // Ping-pong N=3, period 2
    setup(2'b01, 3, 2);
    repeat (16) tick();

    // One-shot N=3, period 3, then restart
    setup(2'b10, 3, 3);
    repeat (9) tick();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_frame", 32'(frame_actual), 32'd2);
    chk("t3_nopulse", 32'(frame_changed), 32'd0);
    repeat (3) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t3_restart_f", 32'(frame_actual), 32'd0);
    chk("t3_restart_p", 32'(frame_changed), 32'd1);
    chk("t3_restart_d", 32'(done), 32'd0);
    repeat (4) tick();

    // Pause after 2 counts, two steps, release
    setup(2'b00, 8, 5);
    repeat (2) tick();
    pause = 1'b1;
    repeat (12) tick();
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0; tick();
    chk("t4_steps", 32'(frame_actual), 32'd2);
    pause = 1'b0;
    repeat (12) tick();

    // Default period and clamped frame count
    setup(2'b00, 31, 0);
    repeat (6 * 18) tick();

    // Async reset mid-run at frame 2
    setup(2'b00, 4, 3);
    repeat (7) tick();
    chk("t6_pre", 32'(frame_actual), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    tick();
    #2;
    rst_n = 1'b1;
    repeat (8) tick();

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom % 80) != 0;
      restart = ($urandom % 50) == 0;
      step    = ($urandom % 5) == 0;
      if (($urandom % 10) == 0) pause = ~pause;
      if (($urandom % 25) == 0) begin
        mode       = 2'($urandom % 4);
        num_frames = (FW + 1)'($urandom % 32);
        speed      = 32'($urandom % 8);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
